// File: rtl/bp_be_fe_queue_buffer_pkg.sv
// Shared definitions for the backend FE-queue buffer: entry width helper and
// pointer-update operation encoding.
package bp_be_fe_queue_buffer_pkg;

    localparam int unsigned fe_msg_type_width_lp = 2;

    // An FE queue entry carries a virtual address, branch metadata and a message type.
    function automatic int unsigned bp_fe_queue_width(input int unsigned vaddr_w,
                                                      input int unsigned meta_w);
        return vaddr_w + meta_w + fe_msg_type_width_lp;
    endfunction

    typedef enum logic [1:0] {
        e_ptr_hold = 2'd0,
        e_ptr_inc  = 2'd1,
        e_ptr_load = 2'd2
    } ptr_op_e;

endpackage

// File: rtl/bp_be_fe_queue_buffer_ptr.sv
// Wrap-bit pointer counter: load has priority over increment; natural overflow
// of the extra MSB provides the wrap bit.
module bp_be_fe_queue_ptr
    import bp_be_fe_queue_buffer_pkg::*;
#(
    parameter int ptr_width_p = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   inc_i,
    input  logic                   load_i,
    input  logic [ptr_width_p-1:0] load_val_i,
    output logic [ptr_width_p-1:0] ptr_o
);

    logic [ptr_width_p-1:0] r_ptr;
    ptr_op_e                w_op;

    // Select this cycle's pointer operation
    always_comb begin
        w_op = e_ptr_hold;
        if (load_i) begin
            w_op = e_ptr_load;
        end else if (inc_i) begin
            w_op = e_ptr_inc;
        end else begin
            w_op = e_ptr_hold;
        end
    end

    // Pointer register with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_ptr <= '0;
        end else begin
            case (w_op)
                e_ptr_inc:  r_ptr <= r_ptr + ptr_width_p'(1);
                e_ptr_load: r_ptr <= load_val_i;
                default:    r_ptr <= r_ptr;
            endcase
        end
    end

    assign ptr_o = r_ptr;

endmodule

// File: rtl/bp_be_fe_queue_buffer.sv
// Backend FE-queue buffer with speculative dequeue: entries remain resident
// until committed, roll replays uncommitted entries, clr flushes everything.
module bp_be_fe_queue_buffer
    import bp_be_fe_queue_buffer_pkg::*;
#(
    parameter  int vaddr_width_p               = 16,
    parameter  int branch_metadata_fwd_width_p = 8,
    parameter  int els_p                       = 8,
    localparam int fe_queue_width_lp           = int'(bp_fe_queue_width(vaddr_width_p, branch_metadata_fwd_width_p)),
    localparam int ptr_width_lp                = $clog2(els_p) + 1
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [fe_queue_width_lp-1:0] fe_queue_i,
    input  logic                         fe_queue_v_i,
    output logic                         fe_queue_ready_o,
    output logic [fe_queue_width_lp-1:0] fe_queue_o,
    output logic                         fe_queue_v_o,
    input  logic                         fe_queue_yumi_i,
    input  logic                         commit_i,
    input  logic                         roll_i,
    input  logic                         clr_i,
    output logic                         empty_o
);

    localparam int idx_width_lp = ptr_width_lp - 1;

    logic [fe_queue_width_lp-1:0] r_mem [els_p];

    logic [ptr_width_lp-1:0] w_wptr;
    logic [ptr_width_lp-1:0] w_rptr;
    logic [ptr_width_lp-1:0] w_cptr;
    logic [ptr_width_lp-1:0] w_cptr_next;
    logic [ptr_width_lp-1:0] w_rptr_load_val;
    logic                    w_full;
    logic                    w_ready;
    logic                    w_valid;
    logic                    w_enq;
    logic                    w_deq;
    logic                    w_commit;
    logic                    w_rptr_load;

    // Space is reclaimed only on commit, so fullness compares against cptr.
    assign w_full   = (w_wptr[idx_width_lp-1:0] == w_cptr[idx_width_lp-1:0])
                    & (w_wptr[idx_width_lp] != w_cptr[idx_width_lp]);
    assign w_ready  = ~w_full & ~clr_i;
    assign w_valid  = (w_rptr != w_wptr) & ~roll_i & ~clr_i;
    assign w_enq    = fe_queue_v_i & w_ready;
    assign w_deq    = fe_queue_yumi_i & w_valid;
    assign w_commit = commit_i & ~clr_i;

    // Roll target includes a same-cycle commit; clr rewinds everything to zero
    always_comb begin
        w_cptr_next     = w_cptr;
        w_rptr_load     = 1'b0;
        w_rptr_load_val = '0;
        if (w_commit) begin
            w_cptr_next = w_cptr + ptr_width_lp'(1);
        end else begin
            w_cptr_next = w_cptr;
        end
        if (clr_i) begin
            w_rptr_load     = 1'b1;
            w_rptr_load_val = '0;
        end else if (roll_i) begin
            w_rptr_load     = 1'b1;
            w_rptr_load_val = w_cptr_next;
        end else begin
            w_rptr_load     = 1'b0;
            w_rptr_load_val = '0;
        end
    end

    bp_be_fe_queue_ptr #(.ptr_width_p(ptr_width_lp)) u_wptr (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .inc_i      (w_enq),
        .load_i     (clr_i),
        .load_val_i ({ptr_width_lp{1'b0}}),
        .ptr_o      (w_wptr)
    );

    bp_be_fe_queue_ptr #(.ptr_width_p(ptr_width_lp)) u_rptr (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .inc_i      (w_deq),
        .load_i     (w_rptr_load),
        .load_val_i (w_rptr_load_val),
        .ptr_o      (w_rptr)
    );

    bp_be_fe_queue_ptr #(.ptr_width_p(ptr_width_lp)) u_cptr (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .inc_i      (w_commit),
        .load_i     (clr_i),
        .load_val_i ({ptr_width_lp{1'b0}}),
        .ptr_o      (w_cptr)
    );

    // Entry storage: one write port, contents intentionally not reset
    always_ff @(posedge clk_i) begin
        if (reset_n_i && w_enq) begin
            r_mem[w_wptr[idx_width_lp-1:0]] <= fe_queue_i;
        end
    end

    assign fe_queue_o       = r_mem[w_rptr[idx_width_lp-1:0]];
    assign fe_queue_v_o     = w_valid;
    assign fe_queue_ready_o = w_ready;
    assign empty_o          = (w_wptr == w_cptr);

endmodule

// File: tb/tb_bp_be_fe_queue_buffer.sv
// Bench for bp_be_fe_queue_buffer: directed scenarios followed by random traffic,
// all checked against a queue-based reference model.
module tb_bp_be_fe_queue_buffer;
    import bp_be_fe_queue_buffer_pkg::*;

    localparam int ELS = 8;
    localparam int DW  = int'(bp_fe_queue_width(16, 8));

    logic          clk = 1'b0;
    logic          reset_n_i;
    logic [DW-1:0] fe_queue_i;
    logic          fe_queue_v_i;
    logic          fe_queue_ready_o;
    logic [DW-1:0] fe_queue_o;
    logic          fe_queue_v_o;
    logic          fe_queue_yumi_i;
    logic          commit_i;
    logic          roll_i;
    logic          clr_i;
    logic          empty_o;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: resident entries oldest-first, rd = number read but not committed
    logic [DW-1:0] q[$];
    int            rd = 0;

    always #5 clk = ~clk;

    bp_be_fe_queue_buffer #(
        .vaddr_width_p(16), .branch_metadata_fwd_width_p(8), .els_p(ELS)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n_i),
        .fe_queue_i(fe_queue_i), .fe_queue_v_i(fe_queue_v_i), .fe_queue_ready_o(fe_queue_ready_o),
        .fe_queue_o(fe_queue_o), .fe_queue_v_o(fe_queue_v_o), .fe_queue_yumi_i(fe_queue_yumi_i),
        .commit_i(commit_i), .roll_i(roll_i), .clr_i(clr_i), .empty_o(empty_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, compare outputs with the model, then advance the model
    task automatic step(input logic v, input logic [DW-1:0] d, input logic y,
                        input logic c, input logic r, input logic cl, input logic rn);
        logic e_ready, e_v, e_empty;
        @(negedge clk);
        fe_queue_v_i = v; fe_queue_i = d; fe_queue_yumi_i = y;
        commit_i = c; roll_i = r; clr_i = cl; reset_n_i = rn;
        #1;
        e_ready = (q.size() < ELS) && !cl;
        e_v     = (rd < q.size()) && !r && !cl;
        e_empty = (q.size() == 0);
        chk("ready", 32'(fe_queue_ready_o), 32'(e_ready));
        chk("v_o",   32'(fe_queue_v_o),     32'(e_v));
        chk("empty", 32'(empty_o),          32'(e_empty));
        if (e_v) chk("data", 32'(fe_queue_o), 32'(q[rd]));
        @(posedge clk);
        if (!rn || cl) begin
            q.delete();
            rd = 0;
        end else begin
            if (c && q.size() > 0) begin
                void'(q.pop_front());
                rd--;
            end
            if (r) rd = 0;
            else if (y && e_v) rd++;
            if (v && e_ready) q.push_back(d);
        end
    endtask

    // Idle cycle used to inspect outputs against fixed expected values
    task automatic peek(input string tag, input logic rdy, input logic v,
                        input logic [DW-1:0] dat, input logic emp);
        @(negedge clk);
        fe_queue_v_i = 1'b0; fe_queue_yumi_i = 1'b0; commit_i = 1'b0;
        roll_i = 1'b0; clr_i = 1'b0; reset_n_i = 1'b1;
        #1;
        chk({tag, ".ready"}, 32'(fe_queue_ready_o), 32'(rdy));
        chk({tag, ".v_o"},   32'(fe_queue_v_o),     32'(v));
        chk({tag, ".empty"}, 32'(empty_o),          32'(emp));
        if (v) chk({tag, ".data"}, 32'(fe_queue_o), 32'(dat));
    endtask

    function automatic logic [DW-1:0] ent(input int i);
        return DW'(32'hA0 + i);
    endfunction

    initial begin
        logic          rv, ry, rc, rr, rcl, rrn;
        logic [DW-1:0] rdat;
        reset_n_i = 1'b0; fe_queue_i = '0; fe_queue_v_i = 1'b0; fe_queue_yumi_i = 1'b0;
        commit_i = 1'b0; roll_i = 1'b0; clr_i = 1'b0;

        // 1: reset, fill to full, refused 9th enq, 1-cycle visibility
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        peek("reset", 1'b1, 1'b0, '0, 1'b1);
        step(1'b1, ent(0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        peek("first_vis", 1'b1, 1'b1, ent(0), 1'b0);
        for (int i = 1; i < 8; i++) step(1'b1, ent(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        peek("full", 1'b0, 1'b1, ent(0), 1'b0);
        step(1'b1, ent(8), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        peek("held9", 1'b0, 1'b1, ent(0), 1'b0);

        // 2: reads without commit keep it full; one commit frees a slot, wrap enq
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        peek("yumi_nocommit", 1'b0, 1'b1, ent(3), 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        peek("after_commit", 1'b1, 1'b1, ent(3), 1'b0);
        step(1'b1, ent(9), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        peek("wrap_drained", 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // 3: roll replays uncommitted entries in order
        for (int i = 0; i < 3; i++) step(1'b1, ent(16 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        peek("after_roll", 1'b1, 1'b1, ent(16), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        peek("replayed", 1'b1, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // 4: yumi + commit + roll together; roll lands on the committed point
        step(1'b1, ent(32), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, ent(33), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        peek("commit_roll", 1'b1, 1'b1, ent(33), 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // 5: clr drops a same-cycle enq and empties the buffer
        for (int i = 0; i < 5; i++) step(1'b1, ent(48 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, ent(60), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        peek("after_clr", 1'b1, 1'b0, '0, 1'b1);

        // 6: random traffic with a one-cycle reset in the middle
        for (int i = 0; i < 200; i++) begin
            rrn  = (i != 100);
            rcl  = ($urandom_range(0, 19) == 0);
            rr   = ($urandom_range(0, 9) == 0);
            rv   = 1'($urandom_range(0, 1));
            rdat = DW'($urandom);
            ry   = (!rcl && !rr && rd < q.size()) ? 1'($urandom_range(0, 1)) : 1'b0;
            rc   = (rd > 0) ? ($urandom_range(0, 2) == 0) : 1'b0;
            step(rv, rdat, ry, rc, rr, rcl, rrn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
